pa_ifu_ipack_rd: RTL
====================

Name: pa_ifu_ipack_rd

Overview:
- Read side of the IFU instruction package buffer. The write side fills 16-bit halfword entries. This block consumes them in order from a circular read pointer.
- Assembles 16-bit RVC or 32-bit instructions from one or two consecutive entries and presents them to decode through a registered valid/ready stage.
- Pulses a per-entry retire for every consumed entry and forwards bus access errors with the instruction.

Parameters:
- ENTRY_NUM, 4: number of buffer entries. Power of two, >=2.
- PTR_W, 2: read pointer width. Equals log2(ENTRY_NUM).

Ports:
- forever_cpuclk  in  1  clock
- cpurst  in  1  reset, synchronous, active-high
- ipack_buf_flush  in  1  buffer flush (redirect)
- ipack_entry_vld  in  ENTRY_NUM  per-entry valid
- ipack_entry_inst  in  16*ENTRY_NUM  per-entry halfword; entry i at [16i+15:16i]
- ipack_entry_acc_err  in  ENTRY_NUM  per-entry access error
- ipack_entry_retire_en  out  ENTRY_NUM  one-cycle retire pulse per entry, combinational
- ipack_rd_ptr  out  PTR_W  current read pointer (head entry index)
- dec_ipack_ready  in  1  decode accepts the output stage
- ipack_dec_inst_vld  out  1  output instruction valid
- ipack_dec_inst  out  32  instruction; upper 16 bits zero for 16-bit
- ipack_dec_inst_32  out  1  1 = 32-bit instruction
- ipack_dec_acc_err  out  1  access error on any consumed halfword

Behaviour:
- Reset (cpurst=1 at clock edge): rd_ptr=0, inst_vld=0, inst=0, inst_32=0, acc_err=0. ipack_entry_retire_en=0 while cpurst=1.
- Entry selection:
  - head = entry[rd_ptr], nxt = entry[(rd_ptr+1) mod ENTRY_NUM].
  - is32 = head.inst[1:0]==2'b11.
- can_issue = head_vld & (~is32 | head_acc_err | nxt_vld).
  - A head with acc_err issues alone: 1 entry consumed, inst={16'b0,head}, inst_32=is32, acc_err=1.
- Load rule: load = can_issue & (~inst_vld | dec_ipack_ready) & ~ipack_buf_flush & ~cpurst.
- On load, the output registers capture the instruction:
  - 16-bit: inst={16'b0,head}, inst_32=0, acc_err=head_err, consumed=1.
  - 32-bit (head not err): inst={nxt,head}, inst_32=1, acc_err=nxt_err, consumed=2.
- On load:
  - retire_en asserts one-hot on rd_ptr, or on rd_ptr and rd_ptr+1 when consumed=2, in the same cycle.
  - rd_ptr <= rd_ptr+consumed, truncated to PTR_W (wraps mod ENTRY_NUM; e.g. 3+2 -> 1 for N=4).
- inst_vld next-state priority: cpurst -> 0; flush -> 0; load -> 1; dec_ipack_ready -> 0; else hold.
- Data registers change only on load. When idle they hold their last value.
- Throughput: one instruction per cycle when decode is ready every cycle and entries are present. Latency from entry valid to inst_vld is 1 cycle.
- Back-pressure: while inst_vld=1 and dec_ipack_ready=0, there is no load, no retire, and the output is held stable.
- Flush:
  - Clears inst_vld and sets rd_ptr=0 at the next edge.
  - Suppresses load and retire in the flush cycle, even if can_issue=1.
  - The write side clears entry valids on the same flush.
- 32-bit head with nxt invalid and no head error: stall with no retire, including across the wrap point (head = entry N-1, nxt = entry 0).
- Retire is asserted only on valid entries. The write side creates only into invalid entries, so retire and create never target the same entry in the same cycle.
- Reset asserted mid-stall or mid-handshake: all state returns to reset values at that edge. Any pending output is dropped.

Test Plan:
- After reset, load entry0=16'h4501 (RVC) valid -> next cycle inst_vld=1, inst=32'h0000_4501, inst_32=0; retire_en=4'b0001 in the load cycle; rd_ptr=1.
- entry1=16'h0513, entry2=16'h0000, both valid, rd_ptr=1 -> inst=32'h0000_0513, inst_32=1, retire_en=4'b0110, rd_ptr=3.
- rd_ptr=3, entry3=16'h0093 valid, entry0 invalid -> no issue, no retire. Set entry0=16'h0010 valid -> inst=32'h0010_0093, retire_en=4'b1001, rd_ptr=1 (wrap).
- Hold dec_ipack_ready=0 with inst_vld=1 and 2 more RVC entries valid -> output stable, retire_en=0 for 5 cycles. Raise ready -> back-to-back issue, one per cycle.
- Head acc_err=1 with inst[1:0]=11 and nxt invalid -> issues immediately: acc_err=1, inst_32=1, single retire, rd_ptr+1. Also: 32-bit with nxt acc_err=1 -> acc_err=1, two retires.
- Assert flush in a cycle where can_issue=1 -> retire_en=0, next cycle inst_vld=0, rd_ptr=0. Assert cpurst mid-stall -> all outputs return to reset values.

Source files
------------

// File: rtl/pa_ifu_ipack_rd.sv
// rtl/pa_ifu_ipack_rd.sv - IFU instruction package buffer read side and decode output stage
module pa_ifu_ipack_rd #(
    parameter int ENTRY_NUM = 4,
    parameter int PTR_W     = 2
) (
    input  logic                     forever_cpuclk,
    input  logic                     cpurst,
    input  logic                     ipack_buf_flush,
    input  logic [ENTRY_NUM-1:0]     ipack_entry_vld,
    input  logic [16*ENTRY_NUM-1:0]  ipack_entry_inst,
    input  logic [ENTRY_NUM-1:0]     ipack_entry_acc_err,
    output logic [ENTRY_NUM-1:0]     ipack_entry_retire_en,
    output logic [PTR_W-1:0]         ipack_rd_ptr,
    input  logic                     dec_ipack_ready,
    output logic                     ipack_dec_inst_vld,
    output logic [31:0]              ipack_dec_inst,
    output logic                     ipack_dec_inst_32,
    output logic                     ipack_dec_acc_err
);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] nxt_ptr;
    logic [PTR_W-1:0] ptr_step;
    logic [15:0]      head_inst;
    logic [15:0]      nxt_inst;
    logic             head_vld;
    logic             nxt_vld;
    logic             head_err;
    logic             nxt_err;
    logic             is32;
    logic             take_two;
    logic             can_issue;
    logic             load;
    logic             inst_vld;
    logic [31:0]      inst;
    logic             inst_32;
    logic             acc_err;

    assign nxt_ptr = rd_ptr + PTR_W'(1);

    // Pick the head entry and the one after it (wrapping) out of the buffer.
    always_comb begin
        head_inst = '0;
        nxt_inst  = '0;
        head_vld  = 1'b0;
        nxt_vld   = 1'b0;
        head_err  = 1'b0;
        nxt_err   = 1'b0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (PTR_W'(i) == rd_ptr) begin
                head_inst = ipack_entry_inst[16*i +: 16];
                head_vld  = ipack_entry_vld[i];
                head_err  = ipack_entry_acc_err[i];
            end
            if (PTR_W'(i) == nxt_ptr) begin
                nxt_inst = ipack_entry_inst[16*i +: 16];
                nxt_vld  = ipack_entry_vld[i];
                nxt_err  = ipack_entry_acc_err[i];
            end
        end
    end

    // A faulting head always leaves alone so the error reaches decode without waiting on nxt.
    assign is32      = (head_inst[1:0] == 2'b11);
    assign take_two  = is32 & ~head_err;
    assign can_issue = head_vld & (~take_two | nxt_vld);
    assign load      = can_issue & (~inst_vld | dec_ipack_ready) & ~ipack_buf_flush & ~cpurst;
    assign ptr_step  = take_two ? PTR_W'(2) : PTR_W'(1);

    // Retire pulses follow the load in the same cycle: head, plus nxt for a 32-bit pair.
    always_comb begin
        ipack_entry_retire_en = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            ipack_entry_retire_en[i] = load & ((PTR_W'(i) == rd_ptr) |
                                               (take_two & (PTR_W'(i) == nxt_ptr)));
        end
    end

    // Read pointer: reset and flush return to entry 0, a load advances by the entries consumed.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            rd_ptr <= '0;
        end else if (ipack_buf_flush) begin
            rd_ptr <= '0;
        end else if (load) begin
            rd_ptr <= rd_ptr + ptr_step;
        end
    end

    // Output valid: cleared by reset/flush, set by a load, dropped once decode takes it.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            inst_vld <= 1'b0;
        end else if (ipack_buf_flush) begin
            inst_vld <= 1'b0;
        end else if (load) begin
            inst_vld <= 1'b1;
        end else if (dec_ipack_ready) begin
            inst_vld <= 1'b0;
        end
    end

    // Output data only changes on a load so it stays stable under back-pressure.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            inst    <= '0;
            inst_32 <= 1'b0;
            acc_err <= 1'b0;
        end else if (load) begin
            inst    <= take_two ? {nxt_inst, head_inst} : {16'b0, head_inst};
            inst_32 <= is32;
            acc_err <= take_two ? nxt_err : head_err;
        end
    end

    assign ipack_rd_ptr       = rd_ptr;
    assign ipack_dec_inst_vld = inst_vld;
    assign ipack_dec_inst     = inst;
    assign ipack_dec_inst_32  = inst_32;
    assign ipack_dec_acc_err  = acc_err;

endmodule
